// File: rtl/eth_frame_checker_pkg.sv
// Shared definitions for the Ethernet receive frame checker.
// Holds the FSM state encoding, error-bit positions, CRC-32 constants
// and the byte-wise CRC update and bit-reverse helpers.
package eth_frame_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  // Bit positions inside frame_err_o
  localparam int ERR_PRE  = 0;  // wrong preamble length
  localparam int ERR_SFD  = 1;  // bad byte before SFD, or frame ended in preamble
  localparam int ERR_CRC  = 2;  // FCS mismatch
  localparam int ERR_LEN  = 3;  // runt or oversize
  localparam int ERR_RXER = 4;  // rx_er seen during the frame
  localparam int ERR_DRIB = 5;  // odd nibble count in nibble mode

  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  // Residue in normal (MSB-first) bit order; the reflected register is
  // bit-reversed before being compared against it.
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  // One byte through the reflected CRC-32, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_nibble_packer.sv
// Turns MII nibble beats or GMII byte beats into a byte-valid stream.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   byte_mode_i      : 1 = each beat is a byte, 0 = each beat is a nibble
//   beat_v_i         : beat valid
//   data_i           : beat data ([3:0] only in nibble mode)
//   flush_i          : drop any pending half byte
//   byte_v_o/byte_o  : completed byte (combinational, same cycle as its last beat)
//   half_o           : a low nibble is pending
module eth_nibble_packer (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       byte_mode_i,
  input  logic       beat_v_i,
  input  logic [7:0] data_i,
  input  logic       flush_i,
  output logic       byte_v_o,
  output logic [7:0] byte_o,
  output logic       half_o
);

  logic       half_q, half_d;
  logic [3:0] low_q, low_d;

  always_comb begin
    byte_v_o = 1'b0;
    byte_o   = data_i;
    half_d   = half_q;
    low_d    = low_q;
    if (flush_i) begin
      half_d = 1'b0;
    end else if (beat_v_i) begin
      if (byte_mode_i) begin
        byte_v_o = 1'b1;
      end else if (!half_q) begin
        half_d = 1'b1;
        low_d  = data_i[3:0];
      end else begin
        // Low nibble arrives first on the wire
        half_d   = 1'b0;
        byte_v_o = 1'b1;
        byte_o   = {data_i[3:0], low_q};
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      half_q <= 1'b0;
      low_q  <= 4'h0;
    end else begin
      half_q <= half_d;
      low_q  <= low_d;
    end
  end

  assign half_o = half_q;

endmodule

// File: rtl/eth_frame_checker.sv
// Ethernet receive frame checker: preamble/SFD, CRC-32, length, rx_er and
// dribble checks, with per-frame result and good/bad frame statistics.
// Ports:
//   clk_i, reset_n_i        : clock, asynchronous active-low reset
//   speed_i                 : 2'b10 byte mode, otherwise nibble mode (latched per frame)
//   rx_dv_i, rx_er_i, rxd_i : receive beat
//   clear_stats_i           : zero both statistics counters
//   frame_v_o               : one-cycle end-of-frame pulse
//   frame_ok_o/err_o/len_o  : result of the last frame, held until the next pulse
//   good_cnt_o, bad_cnt_o   : saturating frame counters
module eth_frame_checker
  import eth_frame_checker_pkg::*;
#(
  parameter int max_frame_bytes_p = 1518,
  parameter int min_frame_bytes_p = 64,
  parameter int preamble_len_p    = 7,
  parameter int stat_width_p      = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [1:0]              speed_i,
  input  logic                    rx_dv_i,
  input  logic                    rx_er_i,
  input  logic [7:0]              rxd_i,
  input  logic                    clear_stats_i,
  output logic                    frame_v_o,
  output logic                    frame_ok_o,
  output logic [5:0]              frame_err_o,
  output logic [15:0]             frame_len_o,
  output logic [stat_width_p-1:0] good_cnt_o,
  output logic [stat_width_p-1:0] bad_cnt_o
);

  localparam logic [15:0] MIN_LEN = 16'(min_frame_bytes_p);
  localparam logic [15:0] MAX_LEN = 16'(max_frame_bytes_p);
  localparam logic [3:0]  PRE_LEN = 4'(preamble_len_p);

  state_e      state_q, state_d;
  logic        wait_q;
  logic        byte_mode_q, byte_mode_d, byte_mode_eff;
  logic [3:0]  pre_cnt_q, pre_cnt_d, pre_base;
  logic [15:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;
  logic [5:0]  err_q, err_d, err_now, err_fin;
  logic        frame_v_q, frame_ok_q;
  logic [5:0]  frame_err_q;
  logic [15:0] frame_len_q;
  logic [stat_width_p-1:0] good_q, bad_q;

  logic       beat_v, byte_v, half;
  logic [7:0] pkt_byte;
  logic       start, pre_phase, data_phase, frame_end, rxer_hit;

  // After reset, beats are ignored until rx_dv has been seen low once
  assign beat_v        = rx_dv_i && !wait_q;
  // The first beat of a frame is decoded with the live speed, later ones with the latched one
  assign byte_mode_eff = (state_q == ST_IDLE) ? (speed_i == 2'b10) : byte_mode_q;

  eth_nibble_packer u_packer (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .byte_mode_i (byte_mode_eff),
    .beat_v_i    (beat_v),
    .data_i      (rxd_i),
    .flush_i     (!rx_dv_i),
    .byte_v_o    (byte_v),
    .byte_o      (pkt_byte),
    .half_o      (half)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (frame_end) begin
      state_d = ST_IDLE;
    end else begin
      if (start) state_d = ST_PRE;
      if (pre_phase && byte_v) begin
        if (pkt_byte == SFD_BYTE)      state_d = ST_DATA;
        else if (pkt_byte != PRE_BYTE) state_d = ST_DROP;
      end
    end
  end

  // FSM outputs; the starting beat is already treated as a preamble beat
  always_comb begin
    start      = (state_q == ST_IDLE) && beat_v;
    pre_phase  = (state_q == ST_PRE) || start;
    data_phase = (state_q == ST_DATA);
    frame_end  = !rx_dv_i && (state_q != ST_IDLE);
    rxer_hit   = beat_v && rx_er_i && (pre_phase || data_phase);
  end

  // Per-frame datapath next state
  always_comb begin
    byte_mode_d = start ? (speed_i == 2'b10) : byte_mode_q;
    pre_base    = start ? 4'h0 : pre_cnt_q;
    pre_cnt_d   = pre_base;
    err_now     = '0;
    if (pre_phase && byte_v) begin
      if (pkt_byte == PRE_BYTE) begin
        if (pre_base != 4'hF) pre_cnt_d = pre_base + 4'h1;
      end else if (pkt_byte == SFD_BYTE) begin
        if (pre_base != PRE_LEN) err_now[ERR_PRE] = 1'b1;
      end else begin
        err_now[ERR_SFD] = 1'b1;
      end
    end
    if (rxer_hit) err_now[ERR_RXER] = 1'b1;
    err_d = (start ? 6'h0 : err_q) | err_now;

    crc_d = start ? CRC_INIT : crc_q;
    len_d = start ? 16'h0 : len_q;
    if (data_phase && byte_v) begin
      crc_d = crc32_byte(crc_q, pkt_byte);
      if (len_q != 16'hFFFF) len_d = len_q + 16'h1;
    end

    // Final error word, used only on the frame-ending clock
    err_fin = err_q;
    if (state_q == ST_PRE) err_fin[ERR_SFD] = 1'b1;
    if (state_q == ST_DATA) begin
      if (bitrev32(crc_q) != CRC_RESIDUE)     err_fin[ERR_CRC] = 1'b1;
      if (len_q < MIN_LEN || len_q > MAX_LEN) err_fin[ERR_LEN] = 1'b1;
    end
    if (!byte_mode_q && half) err_fin[ERR_DRIB] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wait_q      <= 1'b1;
      byte_mode_q <= 1'b0;
      pre_cnt_q   <= 4'h0;
      len_q       <= 16'h0;
      crc_q       <= CRC_INIT;
      err_q       <= 6'h0;
      frame_v_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 6'h0;
      frame_len_q <= 16'h0;
      good_q      <= '0;
      bad_q       <= '0;
    end else begin
      if (!rx_dv_i) wait_q <= 1'b0;
      byte_mode_q <= byte_mode_d;
      pre_cnt_q   <= pre_cnt_d;
      len_q       <= len_d;
      crc_q       <= crc_d;
      err_q       <= err_d;
      frame_v_q   <= frame_end;
      if (frame_end) begin
        frame_err_q <= err_fin;
        frame_ok_q  <= (err_fin == 6'h0);
        frame_len_q <= len_q;  // stays 0 unless DATA was reached
      end
      // Statistics are counted on the clock that closes the pulse cycle,
      // so a clear on that same cycle wins
      if (clear_stats_i) begin
        good_q <= '0;
        bad_q  <= '0;
      end else if (frame_v_q) begin
        if (frame_ok_q) begin
          if (good_q != '1) good_q <= good_q + 1'b1;
        end else begin
          if (bad_q != '1) bad_q <= bad_q + 1'b1;
        end
      end
    end
  end

  assign frame_v_o   = frame_v_q;
  assign frame_ok_o  = frame_ok_q;
  assign frame_err_o = frame_err_q;
  assign frame_len_o = frame_len_q;
  assign good_cnt_o  = good_q;
  assign bad_cnt_o   = bad_q;

endmodule

// File: tb/tb_eth_frame_checker.sv
module tb_eth_frame_checker;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [1:0]  speed_i;
  logic        rx_dv_i;
  logic        rx_er_i;
  logic [7:0]  rxd_i;
  logic        clear_stats_i;
  logic        frame_v_o;
  logic        frame_ok_o;
  logic [5:0]  frame_err_o;
  logic [15:0] frame_len_o;
  logic [15:0] good_cnt_o;
  logic [15:0] bad_cnt_o;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pulses_before;
  logic [7:0] fb[$];

  eth_frame_checker dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .speed_i       (speed_i),
    .rx_dv_i       (rx_dv_i),
    .rx_er_i       (rx_er_i),
    .rxd_i         (rxd_i),
    .clear_stats_i (clear_stats_i),
    .frame_v_o     (frame_v_o),
    .frame_ok_o    (frame_ok_o),
    .frame_err_o   (frame_err_o),
    .frame_len_o   (frame_len_o),
    .good_cnt_o    (good_cnt_o),
    .bad_cnt_o     (bad_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (frame_v_o === 1'b1) pulses <= pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame: npre x 0x55, SFD, payload bytes 0,1,2..., FCS (complemented CRC, LSB first)
  task automatic make_frame(input int npre, input int npay);
    logic [31:0] c;
    fb.delete();
    for (int i = 0; i < npre; i++) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < npay; i++) begin
      fb.push_back(8'(i));
      c = c ^ {24'h0, 8'(i)};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    fb.push_back(c[7:0]);
    fb.push_back(c[15:8]);
    fb.push_back(c[23:16]);
    fb.push_back(c[31:24]);
  endtask

  task automatic beat(input logic [7:0] d, input logic er);
    rx_dv_i = 1'b1;
    rxd_i   = d;
    rx_er_i = er;
    @(posedge clk_i); #1;
  endtask

  // Send fb[from..to-1]; nib selects nibble beats; er_idx marks an rx_er byte;
  // at chg_idx the speed input is toggled to show it is ignored mid-frame.
  task automatic send_range(input int from, input int to, input logic nib,
                            input int er_idx, input int chg_idx);
    logic [7:0] b;
    for (int i = from; i < to; i++) begin
      b = fb[i];
      if (i == chg_idx) speed_i = nib ? 2'b10 : 2'b00;
      if (nib) begin
        beat({4'hA, b[3:0]}, i == er_idx);
        beat({4'h5, b[7:4]}, i == er_idx);
      end else begin
        beat(b, i == er_idx);
      end
    end
  endtask

  task automatic end_and_check(input string tag, input logic [5:0] e, input logic [15:0] l,
                               input logic [15:0] g, input logic [15:0] b);
    rx_dv_i = 1'b0;
    rx_er_i = 1'b0;
    @(posedge clk_i); #1;
    chk({tag, "_v"},   32'(frame_v_o),   32'd1);
    chk({tag, "_err"}, 32'(frame_err_o), 32'(e));
    chk({tag, "_ok"},  32'(frame_ok_o),  32'(e == 6'h0));
    chk({tag, "_len"}, 32'(frame_len_o), 32'(l));
    @(posedge clk_i); #1;
    chk({tag, "_v_one"}, 32'(frame_v_o),  32'd0);
    chk({tag, "_good"},  32'(good_cnt_o), 32'(g));
    chk({tag, "_bad"},   32'(bad_cnt_o),  32'(b));
    $display("frame %s: err=%b len=%0d good=%0d bad=%0d", tag, frame_err_o, frame_len_o,
             good_cnt_o, bad_cnt_o);
  endtask

  initial begin
    reset_n_i     = 1'b0;
    speed_i       = 2'b10;
    rx_dv_i       = 1'b0;
    rx_er_i       = 1'b0;
    rxd_i         = 8'h00;
    clear_stats_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_v",    32'(frame_v_o),   32'd0);
    chk("rst_ok",   32'(frame_ok_o),  32'd0);
    chk("rst_err",  32'(frame_err_o), 32'd0);
    chk("rst_len",  32'(frame_len_o), 32'd0);
    chk("rst_good", 32'(good_cnt_o),  32'd0);
    chk("rst_bad",  32'(bad_cnt_o),   32'd0);
    reset_n_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // Good 64-byte frame, byte mode
    make_frame(7, 60);
    send_range(0, fb.size(), 1'b0, -1, -1);
    end_and_check("byte_good", 6'b000000, 16'd64, 16'd1, 16'd0);

    // Payload byte 5 bit 0 flipped
    make_frame(7, 60);
    fb[8+5] = fb[8+5] ^ 8'h01;
    send_range(0, fb.size(), 1'b0, -1, -1);
    end_and_check("crc_bad", 6'b000100, 16'd64, 16'd1, 16'd1);

    // Same good frame in nibble mode, speed_i changed mid-frame
    speed_i = 2'b01;
    make_frame(7, 60);
    send_range(0, fb.size(), 1'b1, -1, 30);
    end_and_check("nib_good", 6'b000000, 16'd64, 16'd2, 16'd1);

    // Nibble mode plus one trailing nibble
    speed_i = 2'b01;
    send_range(0, fb.size(), 1'b1, -1, -1);
    beat(8'h0C, 1'b0);
    end_and_check("dribble", 6'b100000, 16'd64, 16'd2, 16'd2);

    // Six preamble bytes
    speed_i = 2'b10;
    make_frame(6, 60);
    send_range(0, fb.size(), 1'b0, -1, -1);
    end_and_check("pre6", 6'b000001, 16'd64, 16'd2, 16'd3);

    // Bad preamble byte 0x57
    make_frame(7, 60);
    fb[3] = 8'h57;
    send_range(0, fb.size(), 1'b0, -1, -1);
    end_and_check("sfd_bad", 6'b000010, 16'd0, 16'd2, 16'd4);

    // 20-byte runt with valid FCS
    make_frame(7, 16);
    send_range(0, fb.size(), 1'b0, -1, -1);
    end_and_check("runt", 6'b001000, 16'd20, 16'd2, 16'd5);

    // rx_er on payload byte 10
    make_frame(7, 60);
    send_range(0, fb.size(), 1'b0, 8 + 10, -1);
    end_and_check("rxer", 6'b010000, 16'd64, 16'd2, 16'd6);

    // rx_dv falls during the preamble
    make_frame(7, 60);
    send_range(0, 3, 1'b0, -1, -1);
    end_and_check("pre_end", 6'b000010, 16'd0, 16'd2, 16'd7);

    // Back-to-back good frames: second starts on the pulse cycle of the first
    make_frame(7, 60);
    pulses_before = pulses;
    send_range(0, fb.size(), 1'b0, -1, -1);
    rx_dv_i = 1'b0;
    @(posedge clk_i); #1;
    chk("b2b_a_v",   32'(frame_v_o),   32'd1);
    chk("b2b_a_err", 32'(frame_err_o), 32'd0);
    send_range(0, fb.size(), 1'b0, -1, -1);
    end_and_check("b2b_b", 6'b000000, 16'd64, 16'd4, 16'd7);
    chk("b2b_pulses", 32'(pulses - pulses_before), 32'd2);

    // Reset asserted at DATA byte 30, rx_dv still high across release
    make_frame(7, 60);
    pulses_before = pulses;
    send_range(0, 8 + 30, 1'b0, -1, -1);
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_good", 32'(good_cnt_o), 32'd0);
    chk("mid_rst_bad",  32'(bad_cnt_o),  32'd0);
    send_range(8 + 30, 8 + 34, 1'b0, -1, -1);
    reset_n_i = 1'b1;
    send_range(8 + 34, fb.size(), 1'b0, -1, -1);
    rx_dv_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    chk("mid_rst_pulses", 32'(pulses - pulses_before), 32'd0);
    chk("mid_rst_good2",  32'(good_cnt_o), 32'd0);
    chk("mid_rst_bad2",   32'(bad_cnt_o),  32'd0);
    $display("reset mid-frame: pulses=%0d good=%0d bad=%0d", pulses - pulses_before,
             good_cnt_o, bad_cnt_o);

    // Frame accepted after reset
    send_range(0, fb.size(), 1'b0, -1, -1);
    end_and_check("post_rst", 6'b000000, 16'd64, 16'd1, 16'd0);

    // Bad frame, then clear coincident with its pulse
    make_frame(7, 16);
    send_range(0, fb.size(), 1'b0, -1, -1);
    rx_dv_i = 1'b0;
    @(posedge clk_i); #1;
    chk("clr_v", 32'(frame_v_o), 32'd1);
    clear_stats_i = 1'b1;
    @(posedge clk_i); #1;
    clear_stats_i = 1'b0;
    chk("clr_good", 32'(good_cnt_o), 32'd0);
    chk("clr_bad",  32'(bad_cnt_o),  32'd0);
    @(posedge clk_i); #1;
    chk("clr_bad_hold", 32'(bad_cnt_o), 32'd0);
    $display("clear on pulse: good=%0d bad=%0d", good_cnt_o, bad_cnt_o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
